// File: rtl/remap_output_mc.sv
// remap_output_mc: multi-channel remap output stage.
//
// Buffers NUM_CH remapped pixel streams in per-channel synchronous FIFOs and
// replays them channel-aligned on a fixed line-period raster, one pixel every
// PIX_DIV clocks. Issues per-line read requests to the remap engines and
// flags per-channel underrun/overflow.
//
// Ports:
//   mpt_clk           clock
//   mpt_arst          synchronous active-high reset
//   rmp_vs            per-channel frame sync, flushes that channel's FIFO
//   rmp_first_line    per-channel first-line marker (OR'd, rising edge = frame start)
//   rmp_in_vld        per-channel write strobe
//   rmp_in_data       per-channel pixel, channel i at [i*DATA_W +: DATA_W]
//   rmp_in_fifo_full  per-channel prog-full
//   rmp_read_ack      per-channel acknowledge of rmp_out_ready
//   rmp_out_ready     line request to the remap engines
//   remap_out_vs      rmp_vs[0] delayed two clocks
//   remap_out_hvld    active line window, aligned to output data
//   remap_out_dvld    output pixel valid
//   remap_out_data    aligned output pixels, same packing as rmp_in_data
//   underrun_err      sticky: read slot found the channel empty
//   overflow_err      sticky: write attempted while the channel was full
//   err_clr           clears both sticky vectors
module remap_output_mc #(
   parameter int unsigned NUM_CH         = 2,
   parameter int unsigned DATA_W         = 8,
   parameter int unsigned VID_HACT       = 1280,
   parameter int unsigned VID_VACT       = 720,
   parameter int unsigned REMAP_OUT_HACT = 6000,
   parameter int unsigned PIX_DIV        = 4,
   parameter int unsigned FIFO_DEPTH     = 2048,
   parameter int unsigned PFULL_MARGIN   = 64
) (
   input  logic                       mpt_clk,
   input  logic                       mpt_arst,
   input  logic [NUM_CH-1:0]          rmp_vs,
   input  logic [NUM_CH-1:0]          rmp_first_line,
   input  logic [NUM_CH-1:0]          rmp_in_vld,
   input  logic [NUM_CH*DATA_W-1:0]   rmp_in_data,
   output logic [NUM_CH-1:0]          rmp_in_fifo_full,
   input  logic [NUM_CH-1:0]          rmp_read_ack,
   output logic                       rmp_out_ready,
   output logic                       remap_out_vs,
   output logic                       remap_out_hvld,
   output logic                       remap_out_dvld,
   output logic [NUM_CH*DATA_W-1:0]   remap_out_data,
   output logic [NUM_CH-1:0]          underrun_err,
   output logic [NUM_CH-1:0]          overflow_err,
   input  logic                       err_clr
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = AW + 1;
   localparam int unsigned XMAX = REMAP_OUT_HACT / PIX_DIV;
   localparam int unsigned XW   = (XMAX > 1) ? $clog2(XMAX) : 1;
   localparam int unsigned YW   = (VID_VACT > 1) ? $clog2(VID_VACT) : 1;
   localparam int unsigned DW   = $clog2(PIX_DIV);

   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_PFULL = CW'(FIFO_DEPTH - PFULL_MARGIN);
   localparam logic [DW-1:0] DIV_LAST  = DW'(PIX_DIV - 1);
   localparam logic [XW-1:0] X_LAST    = XW'(XMAX - 1);
   localparam logic [XW:0]   X_HACT    = (XW + 1)'(VID_HACT);
   localparam logic [YW-1:0] Y_LAST    = YW'(VID_VACT - 1);

   typedef enum logic [1:0] {StIdle, StActive, StBlank} state_e;

   // ---------------------------------------------------------------------
   // Per-channel FIFOs
   // ---------------------------------------------------------------------
   logic [NUM_CH-1:0]        empty;
   logic [NUM_CH-1:0]        ovf_new;
   logic [NUM_CH*DATA_W-1:0] rd_data;
   logic                     pop;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [CW-1:0]     cnt_q;
      logic [AW-1:0]     wr_ptr_q;
      logic [AW-1:0]     rd_ptr_q;
      logic [DATA_W-1:0] rd_data_q;
      logic              full;
      logic              push;

      assign full                = (cnt_q == CNT_FULL);
      assign empty[g]            = (cnt_q == '0);
      // Frame sync blocks writes outright, so a blocked write is not an overflow.
      assign push                = rmp_in_vld[g] & ~rmp_vs[g] & ~full;
      assign ovf_new[g]          = rmp_in_vld[g] & ~rmp_vs[g] & full;
      assign rmp_in_fifo_full[g] = (cnt_q >= CNT_PFULL);
      assign rd_data[g*DATA_W +: DATA_W] = rd_data_q;

      always_ff @(posedge mpt_clk) begin
         if (push) begin
            mem[wr_ptr_q] <= rmp_in_data[g*DATA_W +: DATA_W];
         end
      end

      always_ff @(posedge mpt_clk) begin
         if (mpt_arst) begin
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
         end else begin
            // Read data is still captured on a flush cycle so the popped pixel
            // stays aligned with the other channels.
            if (pop) begin
               rd_data_q <= mem[rd_ptr_q];
            end
            if (rmp_vs[g]) begin
               cnt_q    <= '0;
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
            end else begin
               if (push) begin
                  wr_ptr_q <= wr_ptr_q + AW'(1);
               end
               if (pop) begin
                  rd_ptr_q <= rd_ptr_q + AW'(1);
               end
               if (push && !pop) begin
                  cnt_q <= cnt_q + CW'(1);
               end else if (pop && !push) begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Frame start detection
   // ---------------------------------------------------------------------
   logic fl_q;
   logic fl_prev_q;
   logic frame_start;

   assign frame_start = fl_q & ~fl_prev_q;

   // ---------------------------------------------------------------------
   // Raster FSM and counters
   // ---------------------------------------------------------------------
   state_e          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic [XW-1:0]   x_q, x_d;
   logic [YW-1:0]   y_q, y_d;
   logic            active;
   logic            div_last;
   logic            x_last;
   logic            y_last;
   logic            line_end;
   logic            in_win;
   logic            slot;

   assign active   = (state_q == StActive);
   assign div_last = (div_q == DIV_LAST);
   assign x_last   = (x_q == X_LAST);
   assign y_last   = (y_q == Y_LAST);
   assign line_end = active & div_last & x_last;
   assign in_win   = active & ({1'b0, x_q} < X_HACT);
   assign slot     = in_win & div_last;
   // All channels pop together or not at all, keeping them lock-stepped.
   assign pop      = slot & ~(|empty);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      x_d     = x_q;
      y_d     = y_q;
      if (frame_start) begin
         state_d = StActive;
         div_d   = '0;
         x_d     = '0;
         y_d     = '0;
      end else if (active) begin
         div_d = div_q + DW'(1);
         if (div_last) begin
            div_d = '0;
            if (x_last) begin
               x_d = '0;
               if (y_last) begin
                  y_d     = '0;
                  state_d = StBlank;
               end else begin
                  y_d = y_q + YW'(1);
               end
            end else begin
               x_d = x_q + XW'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Line request handshake
   // ---------------------------------------------------------------------
   logic              ready_q, ready_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [NUM_CH-1:0] ack_acc;
   logic              set_ready;

   assign set_ready = frame_start | (line_end & ~y_last);
   assign ack_acc   = ack_q | (ready_q ? rmp_read_ack : '0);

   always_comb begin
      ready_d = ready_q;
      ack_d   = ack_acc;
      if (set_ready) begin
         // A new request overrides a completion landing on the same cycle.
         ready_d = 1'b1;
         ack_d   = '0;
      end else if (ready_q && (&ack_acc)) begin
         ready_d = 1'b0;
         ack_d   = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Sticky errors
   // ---------------------------------------------------------------------
   logic [NUM_CH-1:0] und_new;
   logic [NUM_CH-1:0] und_q, und_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;

   assign und_new = (slot && (|empty)) ? empty : '0;

   always_comb begin
      und_d = err_clr ? und_new : (und_q | und_new);
      ovf_d = err_clr ? ovf_new : (ovf_q | ovf_new);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic                     pop_q;
   logic                     win_q;
   logic                     vs_q;
   logic                     hvld_q;
   logic                     dvld_q;
   logic                     out_vs_q;
   logic [NUM_CH*DATA_W-1:0] data_q;

   always_ff @(posedge mpt_clk) begin
      if (mpt_arst) begin
         fl_q      <= 1'b0;
         fl_prev_q <= 1'b0;
         state_q   <= StIdle;
         div_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         ready_q   <= 1'b0;
         ack_q     <= '0;
         und_q     <= '0;
         ovf_q     <= '0;
         pop_q     <= 1'b0;
         win_q     <= 1'b0;
         vs_q      <= 1'b0;
         hvld_q    <= 1'b0;
         dvld_q    <= 1'b0;
         out_vs_q  <= 1'b0;
         data_q    <= '0;
      end else begin
         fl_q      <= |rmp_first_line;
         fl_prev_q <= fl_q;
         state_q   <= state_d;
         div_q     <= div_d;
         x_q       <= x_d;
         y_q       <= y_d;
         ready_q   <= ready_d;
         ack_q     <= ack_d;
         und_q     <= und_d;
         ovf_q     <= ovf_d;
         pop_q     <= pop;
         win_q     <= in_win;
         vs_q      <= rmp_vs[0];
         hvld_q    <= win_q;
         dvld_q    <= pop_q;
         out_vs_q  <= vs_q;
         // Output data holds its last value between valid pixels.
         if (pop_q) begin
            data_q <= rd_data;
         end
      end
   end

   assign rmp_out_ready  = ready_q;
   assign remap_out_vs   = out_vs_q;
   assign remap_out_hvld = hvld_q;
   assign remap_out_dvld = dvld_q;
   assign remap_out_data = data_q;
   assign underrun_err   = und_q;
   assign overflow_err   = ovf_q;

endmodule
